// File: rtl/ram_port_arbiter_6502.sv
// Shares one synchronous single-port RAM between the 6502 bus and a host port.
// The CPU always owns the RAM except for short host slots after each clk fall.
module ram_port_arbiter_6502 #(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int HOST_WINDOW = 4
) (
  input  logic          eclk,
  input  logic          ereset,
  input  logic          clk,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] din,
  input  logic          rw,
  output logic [DW-1:0] dout,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          overlap_err
);

  localparam int WW = $clog2(HOST_WINDOW + 1);

  typedef enum logic [1:0] {
    S_CPU,
    S_HOST,
    S_ACK
  } state_t;

  state_t        state;
  logic          clk_q;
  logic [WW-1:0] win_cnt;
  logic          cpu_own_q;
  logic          rd_q;
  logic [DW-1:0] rdata_q;
  logic          fall;
  logic          grant;

  assign fall  = clk_q & ~clk;
  assign grant = (state == S_CPU) & host_req & ~host_ack
               & (win_cnt != '0) & ~fall;

  // Read data is forwarded straight from the RAM during the ack cycle,
  // then held in rdata_q until the next host read completes.
  assign host_rdata = (host_ack & rd_q) ? ram_rdata : rdata_q;

  // RAM port mux: host only in a clean S_HOST cycle, a CPU fall always wins.
  always_comb begin
    ram_addr  = a;
    ram_wdata = din;
    ram_we    = fall & ~rw;
    if (state == S_HOST && !fall) begin
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
      ram_we    = host_we;
    end
  end

  // Arbiter FSM, host window counter and registered outputs.
  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      state       <= S_CPU;
      clk_q       <= 1'b0;
      win_cnt     <= '0;
      cpu_own_q   <= 1'b1;
      dout        <= '0;
      host_ack    <= 1'b0;
      rd_q        <= 1'b0;
      rdata_q     <= '0;
      overlap_err <= 1'b0;
    end else begin
      clk_q     <= clk;
      cpu_own_q <= (state != S_HOST);
      host_ack  <= 1'b0;
      if (fall)
        win_cnt <= WW'(HOST_WINDOW);
      else if (win_cnt != '0)
        win_cnt <= win_cnt - WW'(1);
      if (cpu_own_q)
        dout <= ram_rdata;
      unique case (state)
        S_CPU: begin
          if (grant)
            state <= S_HOST;
        end
        S_HOST: begin
          rd_q <= ~host_we;
          if (fall) begin
            overlap_err <= 1'b1;
            state       <= S_CPU;
          end else begin
            host_ack <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          if (rd_q)
            rdata_q <= ram_rdata;
          state <= S_CPU;
        end
        default: state <= S_CPU;
      endcase
    end
  end

endmodule
